elevator_scan_ctrl: RTL
=======================

ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8, number of served floors (>=2).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 50000000, clock cycles per one-floor move (>=1).
REQ-003 SHALL have parameter DOOR_CYCLES, default 100000000, clock cycles the door dwells open at a serviced floor (>=1).
REQ-004 SHALL have localparam FW = $clog2(NUM_FLOORS), the floor index width.
REQ-005 SHALL use reset rst_n, synchronous, active-low, and clock clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 req_valid  input  1  floor request strobe, sampled every cycle.
REQ-009 req_floor  input  FW  requested floor index.
REQ-010 req_err  output  1  one-cycle pulse for an out-of-range request.
REQ-011 pending  output  NUM_FLOORS  outstanding request bitmap, bit i = floor i.
REQ-012 current_floor  output  FW  floor the car is at or last passed.
REQ-013 door_state  output  door_t  OPEN or CLOSE.
REQ-014 elevator_direction  output  direction_t  IDLE, UP or DOWN.

Function
REQ-015 SHALL implement states IDLE_S (door open, no work), MOVE_S (door closed, travelling), DWELL_S (door open at serviced floor).
REQ-016 Request accept: req_valid with req_floor < NUM_FLOORS SHALL set pending[req_floor] at the next edge; with req_floor >= NUM_FLOORS SHALL leave pending unchanged and assert req_err for exactly the next cycle.
REQ-017 A request for current_floor in IDLE_S or DWELL_S SHALL NOT set pending; it SHALL enter or restart DWELL_S with a full DOOR_CYCLES dwell.
REQ-018 A request for current_floor in MOVE_S SHALL set pending and be served on return (the car is between floors).
REQ-019 Direction decision (from IDLE_S, or at dwell expiry): pending above only -> UP; below only -> DOWN; both -> keep last non-IDLE direction (UP after reset); none -> IDLE_S, elevator_direction IDLE, door stays OPEN.
REQ-020 On a decision to move, SHALL enter MOVE_S next cycle with door_state CLOSE, elevator_direction UP/DOWN, travel counter 0.
REQ-021 In MOVE_S, the travel counter SHALL count 0..TRAVEL_CYCLES-1; on the terminal count current_floor SHALL step +/-1 and the counter SHALL reload 0.
REQ-022 On a step to floor f with pending[f] set, the same edge SHALL clear pending[f], enter DWELL_S, and set door_state OPEN; otherwise MOVE_S continues.
REQ-023 SCAN rule: the car SHALL NOT reverse while any request remains ahead in its current direction.
REQ-024 DWELL_S SHALL last DOOR_CYCLES cycles, then apply REQ-019.
REQ-025 A new request arriving on the same edge that clears that floor's bit SHALL be treated as serviced (clear wins).
REQ-026 current_floor SHALL never leave 0..NUM_FLOORS-1; no step is issued past an end floor.
REQ-027 Counters SHALL be sized $clog2(max(TRAVEL_CYCLES,DOOR_CYCLES)+1) bits.

Reset
REQ-028 While rst_n=0 at an edge: state IDLE_S, current_floor 0, door_state OPEN, elevator_direction IDLE, pending 0, req_err 0, counters 0, last direction UP.
REQ-029 Reset mid-MOVE_S or mid-DWELL_S SHALL discard all pending requests and return the car to floor 0 immediately.

Structure
REQ-030 direction_t, door_t and state_t (IDLE_S, MOVE_S, DWELL_S) SHALL live in the shared types package; NUM_FLOORS-derived widths SHALL stay local.
REQ-031 The above/below pending search SHALL be one sub-module, elevator_req_scan (inputs pending, current_floor; outputs any_above, any_below).

Verification (NUM_FLOORS=6, TRAVEL_CYCLES=4, DOOR_CYCLES=3, FW=3)
REQ-032 Reset, then req 3 at cycle 0 -> MOVE_S from cycle 2, floor 3 with door OPEN 12 cycles later, pending=0, IDLE_S after 3 dwell cycles.
REQ-033 At floor 0 idle, req 4 then req 2 on consecutive cycles -> stops at 2 (dwell 3), then 4, never reversing.
REQ-034 Moving UP from 2 toward 5, req 1 injected at floor 3 -> serves 5 first, then reverses DOWN and serves 1.
REQ-035 Idle at floor 0, req 0 -> DWELL_S for 3 cycles, door OPEN throughout, current_floor stays 0, pending stays 0.
REQ-036 req 7 -> req_err high exactly one cycle, pending unchanged; rst_n low mid-travel at floor 3 -> next cycle floor 0, door OPEN, direction IDLE, pending 0.

Source files
------------

// File: rtl/elevator_scan_ctrl_pkg.sv
// elevator_scan_ctrl_pkg: shared enums for the elevator SCAN controller
package elevator_scan_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, UP, DOWN} direction_t;
    typedef enum logic {OPEN, CLOSE} door_t;
    typedef enum logic [1:0] {IDLE_S, MOVE_S, DWELL_S} state_t;
endpackage

// File: rtl/elevator_req_scan.sv
// elevator_req_scan: flags outstanding requests above and below the car
module elevator_req_scan #(
    parameter int  NUM_FLOORS = 8,
    localparam int FW         = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FW-1:0]         current_floor,
    output logic                  any_above,
    output logic                  any_below
);
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            any_above |= pending[i] && (i > int'(current_floor));
            any_below |= pending[i] && (i < int'(current_floor));
        end
    end
endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN car controller with request bitmap and timed travel/dwell
module elevator_scan_ctrl
    import elevator_scan_ctrl_pkg::*;
#(
    parameter int  NUM_FLOORS    = 8,
    parameter int  TRAVEL_CYCLES = 50000000,
    parameter int  DOOR_CYCLES   = 100000000,
    localparam int FW            = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [FW-1:0]         req_floor,
    output logic                  req_err,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FW-1:0]         current_floor,
    output door_t                 door_state,
    output direction_t            elevator_direction
);
    localparam int MAXC = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_t                state_q, state_d;
    direction_t            dir_q, dir_d, last_q, last_d, go_dir;
    logic [FW-1:0]         floor_q, floor_d, next_floor;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  any_above, any_below, in_range, here, ahead, decide;
    logic                  term_travel, term_door;

    elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan (
        .pending      (pend_q),
        .current_floor(floor_q),
        .any_above    (any_above),
        .any_below    (any_below)
    );

    always_comb begin
        in_range    = int'(req_floor) < NUM_FLOORS;
        here        = req_valid && in_range && req_floor == floor_q && state_q != MOVE_S;
        ahead       = last_q == UP ? any_above : any_below;
        go_dir      = any_above && any_below ? last_q : any_above ? UP : any_below ? DOWN : IDLE;
        next_floor  = last_q == UP ? floor_q + FW'(1) : floor_q - FW'(1);
        term_travel = cnt_q == CW'(TRAVEL_CYCLES - 1);
        term_door   = cnt_q == CW'(DOOR_CYCLES - 1);
        state_d     = state_q;
        dir_d       = dir_q;
        last_d      = last_q;
        floor_d     = floor_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        err_d       = req_valid && !in_range;
        decide      = 1'b0;
        if (req_valid && in_range && !here) pend_d[req_floor] = 1'b1;
        // the service clear below is applied after the set, so a same-edge request is absorbed
        case (state_q)
            IDLE_S: decide = 1'b1;
            DWELL_S: begin
                cnt_d  = term_door ? '0 : cnt_q + CW'(1);
                decide = term_door;
            end
            MOVE_S: begin
                cnt_d = term_travel ? '0 : cnt_q + CW'(1);
                if (term_travel && !ahead) begin
                    state_d = IDLE_S;
                    dir_d   = IDLE;
                end else if (term_travel) begin
                    floor_d = next_floor;
                    if (pend_q[next_floor]) begin
                        pend_d[next_floor] = 1'b0;
                        state_d            = DWELL_S;
                    end
                end
            end
            default: ;
        endcase
        if (here) begin
            state_d = DWELL_S;
            cnt_d   = '0;
        end else if (decide) begin
            state_d = go_dir == IDLE ? IDLE_S : MOVE_S;
            dir_d   = go_dir;
            last_d  = go_dir == IDLE ? last_q : go_dir;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE_S;
            dir_q   <= IDLE;
            last_q  <= UP;
            floor_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
            floor_q <= floor_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign req_err            = err_q;
    assign pending            = pend_q;
    assign current_floor      = floor_q;
    assign door_state         = state_q == MOVE_S ? CLOSE : OPEN;
    assign elevator_direction = dir_q;
endmodule
